// File: rtl/arm_pkg.sv
// arm_pkg: shared types and constants for the ARM memory stage
package arm_pkg;
    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] ARM_ADDR_BASE = 32'd1024;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} mem_state_t;
endpackage

// File: rtl/data_memory.sv
// data_memory: word-wide RAM with synchronous write and combinational read
module data_memory import arm_pkg::*; #(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WORD_W-1:0]        wdata,
    output logic [WORD_W-1:0]        rdata
);
    logic [WORD_W-1:0] mem [DEPTH];
    // Write port; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end
    assign rdata = mem[addr];
endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage with wait-state FSM and MEM/WB register
module mem_stage import arm_pkg::*; #(
    parameter int                DEPTH       = 64,
    parameter logic [WORD_W-1:0] ADDR_BASE   = ARM_ADDR_BASE,
    parameter int                WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] alu_res_MEM,
    input  logic [WORD_W-1:0] rm_val_MEM,
    input  logic [3:0]        dest_MEM,
    input  logic              WB_EN_MEM,
    input  logic              MEM_R_EN_MEM,
    input  logic              MEM_W_EN_MEM,
    output logic              mem_ready,
    output logic [WORD_W-1:0] alu_res_WB,
    output logic [WORD_W-1:0] mem_data_WB,
    output logic [3:0]        dest_WB,
    output logic              WB_EN_WB,
    output logic              MEM_R_EN_WB
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(WAIT_CYCLES + 1);
    mem_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WORD_W-1:0] rdata_q, rdata;
    logic [WORD_W-3:0] word;
    logic mem_en, access, in_range, we;
    assign mem_en    = MEM_R_EN_MEM | MEM_W_EN_MEM;
    assign mem_ready = !mem_en || state_q == DONE;
    // Word offset from the base; byte-offset bits never reach the index
    assign word      = alu_res_MEM[WORD_W-1:2] - ADDR_BASE[WORD_W-1:2];
    assign in_range  = alu_res_MEM >= ADDR_BASE && word[WORD_W-3:AW] == '0;
    assign access    = state_q == BUSY && cnt_q == CW'(WAIT_CYCLES - 1);
    // Simultaneous R/W is treated as a load, and reset kills a pending store
    assign we        = access && MEM_W_EN_MEM && !MEM_R_EN_MEM && in_range && !rst;
    data_memory #(.DEPTH(DEPTH)) u_dmem (
        .clk   (clk),
        .we    (we),
        .addr  (word[AW-1:0]),
        .wdata (rm_val_MEM),
        .rdata (rdata)
    );
    // Wait-state sequencing: IDLE -> BUSY x WAIT_CYCLES -> DONE -> IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (mem_en) begin
                state_d = BUSY;
                cnt_d   = '0;
            end
            BUSY: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = access ? DONE : BUSY;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // FSM state, wait counter and latched load data
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (access) rdata_q <= (MEM_R_EN_MEM && in_range) ? rdata : '0;
        end
    end
    // MEM/WB register: real entry when the stage advances, zero bubble otherwise
    always_ff @(posedge clk) begin
        if (rst || !mem_ready) begin
            alu_res_WB  <= '0;
            mem_data_WB <= '0;
            dest_WB     <= '0;
            WB_EN_WB    <= 1'b0;
            MEM_R_EN_WB <= 1'b0;
        end else begin
            alu_res_WB  <= alu_res_MEM;
            mem_data_WB <= MEM_R_EN_MEM ? rdata_q : '0;
            dest_WB     <= dest_MEM;
            WB_EN_WB    <= WB_EN_MEM;
            MEM_R_EN_WB <= MEM_R_EN_MEM;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: table-driven scoreboard bench for mem_stage
module tb_mem_stage;
    import arm_pkg::*;
    localparam int W = 2;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  dest;
        logic        wb;
        logic        r;
        logic        w;
        logic [31:0] exp;
    } vec_t;
    typedef struct {
        logic [31:0] alu;
        logic [31:0] mdata;
        logic [3:0]  dest;
        logic        wb;
        logic        ren;
    } ent_t;
    logic clk = 0, rst = 1;
    logic [31:0] alu_res_MEM = 0, rm_val_MEM = 0;
    logic [3:0] dest_MEM = 0;
    logic WB_EN_MEM = 0, MEM_R_EN_MEM = 0, MEM_W_EN_MEM = 0;
    logic mem_ready, WB_EN_WB, MEM_R_EN_WB;
    logic [31:0] alu_res_WB, mem_data_WB;
    logic [3:0] dest_WB;
    int n_chk = 0, n_fail = 0, cyc = 0;
    ent_t sb[$];
    int ent_cyc[$];
    vec_t tbl[$];

    mem_stage #(.DEPTH(64), .ADDR_BASE(32'd1024), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .alu_res_MEM(alu_res_MEM), .rm_val_MEM(rm_val_MEM),
        .dest_MEM(dest_MEM), .WB_EN_MEM(WB_EN_MEM), .MEM_R_EN_MEM(MEM_R_EN_MEM),
        .MEM_W_EN_MEM(MEM_W_EN_MEM), .mem_ready(mem_ready), .alu_res_WB(alu_res_WB),
        .mem_data_WB(mem_data_WB), .dest_WB(dest_WB), .WB_EN_WB(WB_EN_WB),
        .MEM_R_EN_WB(MEM_R_EN_WB)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every non-bubble MEM/WB entry must match the oldest expectation
    always @(posedge clk) begin
        #1;
        cyc++;
        if (WB_EN_WB === 1'b1 || MEM_R_EN_WB === 1'b1) begin
            ent_cyc.push_back(cyc);
            if (sb.size() == 0) chk("unexpected_wb_entry", {alu_res_WB, mem_data_WB, dest_WB, WB_EN_WB, MEM_R_EN_WB}, 96'h0);
            else begin
                ent_t e;
                e = sb.pop_front();
                chk("wb_entry", {alu_res_WB, mem_data_WB, dest_WB, WB_EN_WB, MEM_R_EN_WB},
                    {e.alu, e.mdata, e.dest, e.wb, e.ren});
            end
        end
    end

    task automatic drive(input vec_t v);
        alu_res_MEM  = v.addr;
        rm_val_MEM   = v.wdata;
        dest_MEM     = v.dest;
        WB_EN_MEM    = v.wb;
        MEM_R_EN_MEM = v.r;
        MEM_W_EN_MEM = v.w;
    endtask

    task automatic issue(input vec_t v);
        int st;
        ent_t e;
        drive(v);
        #1;
        st = 0;
        while (mem_ready !== 1'b1 && st < 20) begin
            @(posedge clk);
            #1;
            st++;
        end
        chk("stall_cycles", 96'(st), (v.r || v.w) ? 96'(W + 1) : 96'(0));
        if (v.wb || v.r) begin
            e = '{alu: v.addr, mdata: v.r ? v.exp : 32'h0, dest: v.dest, wb: v.wb, ren: v.r};
            sb.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] d, input logic [3:0] ds,
                                input logic wb, input logic r, input logic w, input logic [31:0] ex);
        vec_t v;
        v = '{addr: a, wdata: d, dest: ds, wb: wb, r: r, w: w, exp: ex};
        return v;
    endfunction

    initial begin
        vec_t idle_v;
        int n;
        idle_v = mk(0, 0, 0, 0, 0, 0, 0);
        tbl.push_back(mk(1028, 32'hDEADBEEF, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1028, 0, 1, 1, 1, 0, 32'hDEADBEEF));
        tbl.push_back(mk(5, 0, 3, 1, 0, 0, 0));
        tbl.push_back(mk(1276, 32'hCAFEF00D, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1024, 32'h11111111, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1032, 32'h22222222, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1024, 0, 2, 1, 1, 0, 32'h11111111));
        tbl.push_back(mk(1032, 0, 4, 1, 1, 0, 32'h22222222));
        tbl.push_back(mk(1020, 32'hBAD0BAD0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1020, 0, 5, 1, 1, 0, 32'h0));
        tbl.push_back(mk(1276, 0, 6, 1, 1, 0, 32'hCAFEF00D));
        tbl.push_back(mk(1280, 32'hBAD1BAD1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1280, 0, 7, 1, 1, 0, 32'h0));
        tbl.push_back(mk(1024, 0, 8, 1, 1, 0, 32'h11111111));
        tbl.push_back(mk(1031, 0, 9, 1, 1, 0, 32'hDEADBEEF));
        tbl.push_back(mk(1032, 32'h99999999, 10, 1, 1, 1, 32'h22222222));
        tbl.push_back(mk(1032, 0, 11, 1, 1, 0, 32'h22222222));
        tbl.push_back(mk(32'hABCD, 0, 12, 0, 0, 0, 0));
        tbl.push_back(mk(32'h12345678, 0, 15, 1, 0, 0, 0));

        repeat (2) @(posedge clk);
        #1;
        chk("reset_wb", {alu_res_WB, mem_data_WB, dest_WB, WB_EN_WB, MEM_R_EN_WB}, 96'h0);
        chk("reset_ready", 96'(mem_ready), 96'(1));
        chk("reset_state", 96'(dut.state_q), 96'(IDLE));
        @(negedge clk);
        rst = 0;

        foreach (tbl[i]) issue(tbl[i]);

        n = ent_cyc.size();
        issue(mk(1024, 0, 1, 1, 1, 0, 32'h11111111));
        issue(mk(1032, 0, 2, 1, 1, 0, 32'h22222222));
        chk("b2b_entries", 96'(ent_cyc.size() - n), 96'(2));
        if (ent_cyc.size() - n == 2) chk("b2b_gap", 96'(ent_cyc[n+1] - ent_cyc[n]), 96'(W + 2));

        drive(mk(1024, 32'h55555555, 0, 0, 0, 1, 0));
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_state", 96'(dut.state_q), 96'(BUSY));
        rst = 1;
        @(posedge clk);
        #1;
        chk("midrst_state", 96'(dut.state_q), 96'(IDLE));
        chk("midrst_wb", {alu_res_WB, mem_data_WB, dest_WB, WB_EN_WB, MEM_R_EN_WB}, 96'h0);
        @(negedge clk);
        rst = 0;
        drive(idle_v);
        @(negedge clk);
        issue(mk(1024, 0, 3, 1, 1, 0, 32'h11111111));

        repeat (3) @(negedge clk);
        chk("sb_drained", 96'(sb.size()), 96'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
